// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - nibble-serial sequencer around an external 4-bit adder
//
// Performs a WIDTH-bit addition one nibble per clock using an external
// combinational 4-bit adder. Operands are latched on an accepted start; the
// result and carry-out are presented with a one-cycle done pulse.
//
// Optional feature macro: SERIAL_SUB_EN (adds the sub port; sub=1 computes
// op_a - op_b by latching ~op_b with a forced carry-in of 1).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request, sampled only in IDLE
//   op_a, op_b, cin     operands and carry-in, latched on accepted start
//   sub                 subtract request (SERIAL_SUB_EN only)
//   busy                high while the nibble loop runs
//   done                one-cycle pulse when result/cout are final
//   result, cout        sum register and carry out of the top nibble
//   add_a, add_b        nibble operands to the adder (0 outside RUN)
//   add_cin             carry to the adder (0 outside RUN)
//   add_sum, add_cout   adder outputs

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic             last_nibble;
    logic             b_invert;
    logic             carry_seed;

    assign last_nibble = (idx == IW'(N - 1));

`ifdef SERIAL_SUB_EN
    // Two's-complement subtract: a + ~b + 1.
    assign b_invert   = sub;
    assign carry_seed = sub | cin;
`else
    assign b_invert   = 1'b0;
    assign carry_seed = cin;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_nibble) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Adder drive depends only on registers, so start never reaches an output.
    always_comb begin
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = 4'(a_reg >> {idx, 2'b00});
            add_b   = 4'(b_reg >> {idx, 2'b00});
            add_cin = carry_reg;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_reg     <= op_a;
                        b_reg     <= b_invert ? ~op_b : op_b;
                        carry_reg <= carry_seed;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    result[{idx, 2'b00} +: 4] <= add_sum;
                    carry_reg                 <= add_cout;
                    if (last_nibble) begin
                        cout <= add_cout;
                        idx  <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
